// File: rtl/bcd_master_0_bin2bcd.sv
// Purpose : binary-to-packed-BCD converter (sequential double-dabble, one shift per clock).
// Latency : input accepted at E0, result valid after E0+DATA_W; one word per DATA_W+2 cycles back to back.
// Backpr. : in_ready is low from accept until the result handshakes; the result is held while out_ready=0.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   in_valid/in_ready     sink handshake, in_data = unsigned binary word
//   out_valid/out_ready   source handshake, out_data = packed BCD (ones digit in [3:0])
//   busy                  high while converting or holding a result
module bcd_master_0_bin2bcd #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_data,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_W) + 1;

  // The digit field must be able to hold the largest input value.
  if ((longint'(10) ** DIGITS) <= ((longint'(1) << DATA_W) - 1)) begin : g_digits_chk
    $error("bcd_master_0_bin2bcd: DIGITS too small for DATA_W");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t                    state;
  logic [DATA_W-1:0]         bin_sr;
  logic [BCD_W-1:0]          bcd;
  logic [CNT_W-1:0]          cnt;

  logic [BCD_W-1:0]          adj;
  logic [BCD_W+DATA_W-1:0]   sh;
  logic [BCD_W-1:0]          bcd_nxt;
  logic [DATA_W-1:0]         bin_nxt;

  // One double-dabble iteration: correct every digit >= 5 by +3, then shift
  // the combined {bcd, bin_sr} register left by one. A corrected digit is at
  // most 12, so the 4-bit add never carries into the neighbouring digit.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
    sh      = {adj, bin_sr} << 1;
    bcd_nxt = sh[BCD_W+DATA_W-1:DATA_W];
    bin_nxt = sh[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      bin_sr    <= '0;
      bcd       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            bin_sr   <= in_data;
            bcd      <= '0;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd    <= bcd_nxt;
          bin_sr <= bin_nxt;
          cnt    <= cnt + CNT_W'(1);
          // Last shift: capture the post-shift digits directly as the result.
          if (cnt == CNT_W'(DATA_W - 1)) begin
            out_data  <= bcd_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  function automatic logic digits_ok(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  always @(posedge clk) begin
    if (!reset && state == DONE) begin
      assert (digits_ok(out_data))
        else $error("bcd_master_0_bin2bcd: non-decimal digit in result %h", out_data);
    end
  end
`endif

endmodule
